// File: rtl/bisr_weight_loader.sv
// bisr_weight_loader: fetches one weight tile into a small FIFO, streams it to the allocation stage, then waits for the verdict with a timeout
module bisr_weight_loader #(
  parameter int SYSTOLIC_SIZE  = 8,
  parameter int WEIGHT_WIDTH   = 8,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [MEM_ADDR_WIDTH-1:0]             cmd_base_addr,
  output logic                                  mem_rd_req,
  output logic [MEM_ADDR_WIDTH-1:0]             mem_rd_addr,
  input  logic                                  mem_rd_gnt,
  input  logic                                  mem_rd_data_valid,
  input  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] mem_rd_data,
  output logic                                  alloc_weight_start,
  output logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] alloc_input_weights,
  output logic                                  alloc_weight_valid,
  input  logic                                  alloc_recovery_done,
  input  logic                                  alloc_recovery_success,
  output logic                                  load_busy,
  output logic                                  load_done,
  output logic                                  load_success,
  output logic                                  load_timeout
);
  localparam int RW = SYSTOLIC_SIZE * WEIGHT_WIDTH;
  localparam int CW = $clog2(SYSTOLIC_SIZE + 1);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] ROWS  = CW'(SYSTOLIC_SIZE);
  localparam logic [OW:0]   DEPTH = (OW + 1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, START, STREAM, SETTLE, CHECK, DONE} state_t;
  state_t state, state_nxt;
  logic [MEM_ADDR_WIDTH-1:0] base;
  logic [CW-1:0] req_cnt, beat_cnt;
  logic [OW-1:0] outstanding, fifo_count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] timer;
  logic [RW-1:0] fifo_mem [FIFO_DEPTH];
  logic accept, grant, push, pop, last_beat, check_done, check_expire;
  always_comb begin
    accept       = state == IDLE && cmd_valid;
    mem_rd_req   = (state == START || state == STREAM) && req_cnt < ROWS &&
                   ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH;
    mem_rd_addr  = mem_rd_req ? base + MEM_ADDR_WIDTH'(req_cnt) : '0;
    grant        = mem_rd_req && mem_rd_gnt;
    push         = mem_rd_data_valid && outstanding != '0;
    pop          = state == STREAM && fifo_count != '0 && beat_cnt < ROWS;
    last_beat    = pop && beat_cnt == ROWS - 1'b1;
    check_done   = state == CHECK && alloc_recovery_done;
    check_expire = state == CHECK && timer == TLAST;
    cmd_ready           = state == IDLE;
    load_busy           = state != IDLE;
    alloc_weight_start  = state == START;
    alloc_weight_valid  = pop;
    alloc_input_weights = pop ? fifo_mem[rd_ptr] : '0;
    load_done           = state == DONE;
  end
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = accept ? START : IDLE;
      START:   state_nxt = STREAM;
      STREAM:  state_nxt = last_beat ? SETTLE : STREAM;
      SETTLE:  state_nxt = CHECK;
      CHECK:   state_nxt = (check_done || check_expire) ? DONE : CHECK;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      base         <= '0;
      req_cnt      <= '0;
      beat_cnt     <= '0;
      outstanding  <= '0;
      fifo_count   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      timer        <= '0;
      load_success <= 1'b0;
      load_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      base        <= accept ? cmd_base_addr : base;
      req_cnt     <= accept ? '0 : req_cnt + CW'(grant);
      beat_cnt    <= accept ? '0 : beat_cnt + CW'(pop);
      outstanding <= outstanding + OW'(grant) - OW'(push);
      fifo_count  <= fifo_count + OW'(push) - OW'(pop);
      wr_ptr      <= wr_ptr + PW'(push);
      rd_ptr      <= rd_ptr + PW'(pop);
      timer       <= state == CHECK ? timer + 1'b1 : '0;
      if (accept) begin
        load_success <= 1'b0;
        load_timeout <= 1'b0;
      end else if (check_done) begin
        load_success <= alloc_recovery_success;
        load_timeout <= 1'b0;
      end else if (check_expire) begin
        load_success <= 1'b0;
        load_timeout <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rd_data;
  end
endmodule

// File: tb/tb_bisr_weight_loader.sv
// tb_bisr_weight_loader: directed self-checking bench with a latency/grant-configurable memory responder
module tb_bisr_weight_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_base_addr = '0;
  logic        mem_rd_req;
  logic [15:0] mem_rd_addr;
  logic        mem_rd_gnt = 1'b0;
  logic        mem_rd_data_valid = 1'b0;
  logic [63:0] mem_rd_data = '0;
  logic        alloc_weight_start;
  logic [63:0] alloc_input_weights;
  logic        alloc_weight_valid;
  logic        alloc_recovery_done = 1'b0;
  logic        alloc_recovery_success = 1'b0;
  logic        load_busy, load_done, load_success, load_timeout;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit gnt_alt = 1'b0;
  int lat = 1;
  int acc_cyc, start_cnt, start_cyc, done_cnt, done_cyc;
  logic done_succ, done_to;
  logic [63:0] beat_data [$];
  int          beat_cyc [$];
  logic [15:0] grant_addr [$];
  logic [15:0] resp_addr [$];
  int          resp_due [$];
  bisr_weight_loader dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base_addr(cmd_base_addr), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_gnt(mem_rd_gnt), .mem_rd_data_valid(mem_rd_data_valid), .mem_rd_data(mem_rd_data),
    .alloc_weight_start(alloc_weight_start), .alloc_input_weights(alloc_input_weights),
    .alloc_weight_valid(alloc_weight_valid), .alloc_recovery_done(alloc_recovery_done),
    .alloc_recovery_success(alloc_recovery_success), .load_busy(load_busy),
    .load_done(load_done), .load_success(load_success), .load_timeout(load_timeout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [63:0] row(input logic [15:0] a);
    logic [7:0] b;
    b = a[7:0] + 8'd1;
    return {8{b}};
  endfunction
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (alloc_weight_start) begin start_cnt++; start_cyc = cyc; end
    if (alloc_weight_valid) begin beat_data.push_back(alloc_input_weights); beat_cyc.push_back(cyc); end
    if (load_done) begin done_cnt++; done_cyc = cyc; done_succ = load_success; done_to = load_timeout; end
    mem_rd_data_valid = 1'b0;
    mem_rd_data = '0;
    if (resp_due.size() != 0 && resp_due[0] == cyc) begin
      mem_rd_data_valid = 1'b1;
      mem_rd_data = row(resp_addr.pop_front());
      void'(resp_due.pop_front());
    end
    mem_rd_gnt = gnt_alt ? cyc[0] : 1'b1;
    if (mem_rd_req && mem_rd_gnt) begin
      grant_addr.push_back(mem_rd_addr);
      resp_addr.push_back(mem_rd_addr);
      resp_due.push_back(cyc + lat);
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_busy"}, load_busy, 0);
    check({tag, "_req"}, mem_rd_req, 0);
    check({tag, "_addr"}, mem_rd_addr, 0);
    check({tag, "_start"}, alloc_weight_start, 0);
    check({tag, "_valid"}, alloc_weight_valid, 0);
    check({tag, "_weights"}, alloc_input_weights, 0);
    check({tag, "_done"}, load_done, 0);
    check({tag, "_success"}, load_success, 0);
    check({tag, "_timeout"}, load_timeout, 0);
  endtask
  // mode 0: verdict via done input, 1: no done (timeout), 2: done only in final timer cycle
  task automatic run_tile(input string tag, input logic [15:0] b, input bit alt, input int l,
                          input bit dn, input bit sc, input int mode, input bit ideal);
    int g0, b0, d0, s0, n, pend, maxp, ng, nb, lb;
    gnt_alt = alt;
    lat = l;
    alloc_recovery_done = dn;
    alloc_recovery_success = sc;
    g0 = grant_addr.size(); b0 = beat_data.size(); d0 = done_cnt; s0 = start_cnt;
    cmd_valid = 1'b1;
    cmd_base_addr = b;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    n = 0; maxp = 0;
    while (done_cnt == d0 && n < 400) begin
      pend = (grant_addr.size() - g0) - (beat_data.size() - b0);
      if (pend > maxp) maxp = pend;
      if (mode == 2)
        alloc_recovery_done = (beat_data.size() - b0 == 8) && cyc == beat_cyc[b0 + 7] + 65;
      @(posedge clk); #2;
      n++;
    end
    alloc_recovery_done = 1'b0;
    ng = grant_addr.size() - g0;
    nb = beat_data.size() - b0;
    check({tag, "_finished"}, n < 400, 1);
    check({tag, "_starts"}, start_cnt - s0, 1);
    check({tag, "_start_cyc"}, start_cyc - acc_cyc, 1);
    check({tag, "_grants"}, ng, 8);
    check({tag, "_beats"}, nb, 8);
    check({tag, "_max_pending_ok"}, maxp <= 4, 1);
    for (int i = 0; i < ng && i < 8; i++) check({tag, "_addr"}, grant_addr[g0 + i], 16'(b + i));
    for (int i = 0; i < nb && i < 8; i++) check({tag, "_beat_data"}, beat_data[b0 + i], row(16'(b + i)));
    if (ideal)
      for (int i = 0; i < nb && i < 8; i++) check({tag, "_beat_cyc"}, beat_cyc[b0 + i] - acc_cyc, 3 + i);
    if (nb == 8) begin
      lb = beat_cyc[b0 + 7];
      check({tag, "_done_cyc"}, done_cyc - lb, mode == 0 ? 3 : 66);
    end
    if (ideal) check({tag, "_done_from_accept"}, done_cyc - acc_cyc, 13);
    check({tag, "_success"}, done_succ, mode == 1 ? 1'b0 : sc);
    check({tag, "_timeout_flag"}, done_to, mode == 1);
    check({tag, "_success_held"}, load_success, mode == 1 ? 1'b0 : sc);
    check({tag, "_timeout_held"}, load_timeout, mode == 1);
    check({tag, "_back_idle"}, cmd_ready, 1);
  endtask
  initial begin
    int n, bc;
    repeat (3) @(posedge clk);
    #2;
    check_idle("reset");
    rst = 1'b0;
    @(posedge clk); #2;
    run_tile("ideal", 16'h0000, 1'b0, 1, 1'b1, 1'b1, 0, 1'b1);
    run_tile("slowmem", 16'h0010, 1'b1, 3, 1'b1, 1'b1, 0, 1'b0);
    run_tile("wrap", 16'hFFFE, 1'b0, 1, 1'b1, 1'b1, 0, 1'b1);
    run_tile("early_done", 16'h0040, 1'b1, 2, 1'b1, 1'b0, 0, 1'b0);
    run_tile("timeout", 16'h0080, 1'b0, 1, 1'b0, 1'b1, 1, 1'b0);
    run_tile("final_done", 16'h00A0, 1'b0, 1, 1'b0, 1'b1, 2, 1'b0);
    gnt_alt = 1'b0;
    lat = 3;
    bc = beat_data.size();
    cmd_valid = 1'b1;
    cmd_base_addr = 16'h0100;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    n = 0;
    while (beat_data.size() - bc < 4 && n < 100) begin @(posedge clk); #2; n++; end
    check("rst_reached_4_beats", n < 100, 1);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    check_idle("midrst");
    bc = beat_data.size();
    repeat (10) @(posedge clk);
    #2;
    check("midrst_no_late_beats", beat_data.size() - bc, 0);
    check("midrst_still_idle", load_busy, 0);
    run_tile("after_rst", 16'h0200, 1'b1, 2, 1'b1, 1'b1, 0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
